// File: rtl/interconnect_two_data_to_sifft_pkg.sv
// Shared definitions for the IFFT-side merger and the FFT-side splitter:
// symbol-level state encoding and NFFT / half-symbol size derivation.
package interconnect_two_data_to_sifft_pkg;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        SEND_CHET  = 2'd1,
        SEND_NCHET = 2'd2
    } ic_state_t;

    localparam int SIZE_BUFFER_MIN = 2;

    // Number of bins in one symbol for a given log2 size.
    function automatic int nfft_of(input int size_buffer);
        return 1 << size_buffer;
    endfunction

    // Number of bins in one half-symbol bank.
    function automatic int half_of(input int size_buffer);
        return 1 << (size_buffer - 1);
    endfunction

endpackage

// File: rtl/interconnect_two_data_to_sifft_half_bank_buffer.sv
// One half-symbol I/Q bank: NFFT/2 entries written in order through a
// valid/ready port, a full flag raised on the last write, and an
// asynchronous read port addressed by the merger's read counter.
// Bank contents are deliberately not reset; only the counter and flag are.
module interconnect_two_data_to_sifft_half_bank_buffer
    import interconnect_two_data_to_sifft_pkg::*;
#(
    parameter int SIZE_BUFFER   = 6,
    parameter int DATA_FFT_SIZE = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear_i,
    input  logic                              fill_en_i,
    input  logic                              valid_i,
    input  logic signed [DATA_FFT_SIZE-1:0]   data_i_i,
    input  logic signed [DATA_FFT_SIZE-1:0]   data_q_i,
    output logic                              ready_o,
    output logic                              full_o,
    input  logic        [SIZE_BUFFER-2:0]     rd_addr_i,
    output logic signed [DATA_FFT_SIZE-1:0]   rd_data_i_o,
    output logic signed [DATA_FFT_SIZE-1:0]   rd_data_q_o
);

    localparam int HALF = half_of(SIZE_BUFFER);
    localparam logic [SIZE_BUFFER-1:0] WR_LAST = SIZE_BUFFER'(HALF - 1);

    logic signed [DATA_FFT_SIZE-1:0] mem_i_q [HALF];
    logic signed [DATA_FFT_SIZE-1:0] mem_q_q [HALF];
    logic        [SIZE_BUFFER-1:0]   wr_q;
    logic                            full_q;
    logic                            accept;

    assign ready_o     = fill_en_i && !full_q;
    assign full_o      = full_q;
    assign accept      = valid_i && ready_o;
    assign rd_data_i_o = mem_i_q[rd_addr_i];
    assign rd_data_q_o = mem_q_q[rd_addr_i];

    // Write counter and full flag; full rises on the edge that stores the last entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q   <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            wr_q   <= '0;
            full_q <= 1'b0;
        end else if (accept) begin
            wr_q <= wr_q + 1'b1;
            if (wr_q == WR_LAST) begin
                full_q <= 1'b1;
            end
        end
    end

    // Sample storage, written at the current counter position on each accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_i_q[wr_q[SIZE_BUFFER-2:0]] <= data_i_i;
            mem_q_q[wr_q[SIZE_BUFFER-2:0]] <= data_q_i;
        end
    end

endmodule

// File: rtl/interconnect_two_data_to_sifft.sv
// Merges the even ("chet") and odd ("Nchet") half-symbol streams into one
// serial NFFT-sample stream for the IFFT core: fill both banks, then send
// chet[0..HALF-1] followed by Nchet[0..HALF-1] under ifft_valid/ifft_ready.
// Single buffering: filling and sending never overlap.
// Optional macro IC_TWO_TO_SIFFT_LAST_EN adds a registered ifft_last output
// flagging the final sample of each symbol.
module interconnect_two_data_to_sifft
    import interconnect_two_data_to_sifft_pkg::*;
#(
    parameter int SIZE_BUFFER   = 6,
    parameter int DATA_FFT_SIZE = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [DATA_FFT_SIZE-1:0]   data_chet_i,
    input  logic signed [DATA_FFT_SIZE-1:0]   data_chet_q,
    input  logic                              valid_chet,
    output logic                              ready_chet,
    input  logic signed [DATA_FFT_SIZE-1:0]   data_Nchet_i,
    input  logic signed [DATA_FFT_SIZE-1:0]   data_Nchet_q,
    input  logic                              valid_Nchet,
    output logic                              ready_Nchet,
    output logic signed [DATA_FFT_SIZE-1:0]   data_to_ifft_i,
    output logic signed [DATA_FFT_SIZE-1:0]   data_to_ifft_q,
    output logic                              ifft_valid,
`ifdef IC_TWO_TO_SIFFT_LAST_EN
    output logic                              ifft_last,
`endif
    input  logic                              ifft_ready
);

    localparam int NFFT = nfft_of(SIZE_BUFFER);
    localparam int HALF = half_of(SIZE_BUFFER);
    localparam logic [SIZE_BUFFER:0] RD_HALF = (SIZE_BUFFER + 1)'(HALF);
    localparam logic [SIZE_BUFFER:0] RD_END  = (SIZE_BUFFER + 1)'(NFFT);
`ifdef IC_TWO_TO_SIFFT_LAST_EN
    localparam logic [SIZE_BUFFER:0] RD_LAST = (SIZE_BUFFER + 1)'(NFFT - 1);
`endif

    ic_state_t                       state_q;
    logic        [SIZE_BUFFER:0]     rd_q;
    logic                            valid_q;
    logic signed [DATA_FFT_SIZE-1:0] data_i_q;
    logic signed [DATA_FFT_SIZE-1:0] data_q_q;
`ifdef IC_TWO_TO_SIFFT_LAST_EN
    logic                            last_q;
`endif

    logic                            fill_en;
    logic                            sending;
    logic                            out_fire;
    logic                            clear;
    logic                            chet_full;
    logic                            nchet_full;
    logic signed [DATA_FFT_SIZE-1:0] chet_rd_i;
    logic signed [DATA_FFT_SIZE-1:0] chet_rd_q;
    logic signed [DATA_FFT_SIZE-1:0] nchet_rd_i;
    logic signed [DATA_FFT_SIZE-1:0] nchet_rd_q;
    logic        [SIZE_BUFFER-2:0]   rd_addr;

    assign fill_en  = (state_q == FILL);
    assign sending  = (state_q == SEND_CHET) || (state_q == SEND_NCHET);
    assign out_fire = sending && valid_q && ifft_ready;
    assign clear    = out_fire && (rd_q == RD_END);
    // Low bits of rd address both banks: rd for chet, rd-HALF for Nchet.
    assign rd_addr  = rd_q[SIZE_BUFFER-2:0];

    interconnect_two_data_to_sifft_half_bank_buffer #(
        .SIZE_BUFFER   (SIZE_BUFFER),
        .DATA_FFT_SIZE (DATA_FFT_SIZE)
    ) u_chet_bank (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .fill_en_i   (fill_en),
        .valid_i     (valid_chet),
        .data_i_i    (data_chet_i),
        .data_q_i    (data_chet_q),
        .ready_o     (ready_chet),
        .full_o      (chet_full),
        .rd_addr_i   (rd_addr),
        .rd_data_i_o (chet_rd_i),
        .rd_data_q_o (chet_rd_q)
    );

    interconnect_two_data_to_sifft_half_bank_buffer #(
        .SIZE_BUFFER   (SIZE_BUFFER),
        .DATA_FFT_SIZE (DATA_FFT_SIZE)
    ) u_nchet_bank (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .fill_en_i   (fill_en),
        .valid_i     (valid_Nchet),
        .data_i_i    (data_Nchet_i),
        .data_q_i    (data_Nchet_q),
        .ready_o     (ready_Nchet),
        .full_o      (nchet_full),
        .rd_addr_i   (rd_addr),
        .rd_data_i_o (nchet_rd_i),
        .rd_data_q_o (nchet_rd_q)
    );

    // Symbol FSM with registered output sample, valid and read counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= FILL;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            data_i_q <= '0;
            data_q_q <= '0;
`ifdef IC_TWO_TO_SIFFT_LAST_EN
            last_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (chet_full && nchet_full) begin
                        data_i_q <= chet_rd_i;
                        data_q_q <= chet_rd_q;
                        valid_q  <= 1'b1;
                        rd_q     <= (SIZE_BUFFER + 1)'(1);
                        state_q  <= SEND_CHET;
                    end
                end
                SEND_CHET, SEND_NCHET: begin
                    if (out_fire) begin
                        if (rd_q == RD_END) begin
                            valid_q  <= 1'b0;
                            data_i_q <= '0;
                            data_q_q <= '0;
                            rd_q     <= '0;
                            state_q  <= FILL;
`ifdef IC_TWO_TO_SIFFT_LAST_EN
                            last_q   <= 1'b0;
`endif
                        end else begin
                            data_i_q <= rd_q[SIZE_BUFFER-1] ? nchet_rd_i : chet_rd_i;
                            data_q_q <= rd_q[SIZE_BUFFER-1] ? nchet_rd_q : chet_rd_q;
                            rd_q     <= rd_q + 1'b1;
                            if (rd_q == RD_HALF) begin
                                state_q <= SEND_NCHET;
                            end
`ifdef IC_TWO_TO_SIFFT_LAST_EN
                            last_q   <= (rd_q == RD_LAST);
`endif
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign data_to_ifft_i = data_i_q;
    assign data_to_ifft_q = data_q_q;
    assign ifft_valid     = valid_q;
`ifdef IC_TWO_TO_SIFFT_LAST_EN
    assign ifft_last      = last_q;
`endif

endmodule

// File: tb/tb_interconnect_two_data_to_sifft.sv
// Directed bench for the half-symbol merger at SIZE_BUFFER=3 (NFFT=8).
module tb_interconnect_two_data_to_sifft;

    localparam int SB = 3;
    localparam int DW = 16;

    logic                 clk;
    logic                 reset;
    logic signed [DW-1:0] dci, dcq, dni, dnq;
    logic                 vc, vn;
    logic                 rc, rn;
    logic signed [DW-1:0] oi, oq;
    logic                 ov;
    logic                 ifft_ready;
`ifdef IC_TWO_TO_SIFFT_LAST_EN
    logic                 ol;
`endif

    int tests;
    int fails;

    int got_i [16];
    int got_q [16];
    int got_l [16];
    int got_n;
    int first_c;
    int last_c;

    interconnect_two_data_to_sifft #(
        .SIZE_BUFFER   (SB),
        .DATA_FFT_SIZE (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_chet_i    (dci),
        .data_chet_q    (dcq),
        .valid_chet     (vc),
        .ready_chet     (rc),
        .data_Nchet_i   (dni),
        .data_Nchet_q   (dnq),
        .valid_Nchet    (vn),
        .ready_Nchet    (rn),
        .data_to_ifft_i (oi),
        .data_to_ifft_q (oq),
        .ifft_valid     (ov),
`ifdef IC_TWO_TO_SIFFT_LAST_EN
        .ifft_last      (ol),
`endif
        .ifft_ready     (ifft_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_chet(input int base);
        for (int k = 0; k < 4; k++) begin
            dci = DW'(base + k); dcq = DW'(-(base + k)); vc = 1'b1;
            tick();
        end
        vc = 1'b0;
    endtask

    task automatic fill_nchet(input int base);
        for (int k = 0; k < 4; k++) begin
            dni = DW'(base + k); dnq = DW'(-(base + k)); vn = 1'b1;
            tick();
        end
        vn = 1'b0;
    endtask

    task automatic fill_both(input int cbase, input int nbase);
        for (int k = 0; k < 4; k++) begin
            dci = DW'(cbase + k); dcq = DW'(-(cbase + k)); vc = 1'b1;
            dni = DW'(nbase + k); dnq = DW'(-(nbase + k)); vn = 1'b1;
            tick();
        end
        vc = 1'b0; vn = 1'b0;
    endtask

    // Records every presented sample with ifft_ready held high.
    task automatic collect(input int budget);
        ifft_ready = 1'b1;
        got_n = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < budget; c++) begin
            if (ov) begin
                if (got_n < 16) begin
                    got_i[got_n] = int'(oi);
                    got_q[got_n] = int'(oq);
`ifdef IC_TWO_TO_SIFFT_LAST_EN
                    got_l[got_n] = int'(ol);
`else
                    got_l[got_n] = 0;
`endif
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got_n++;
            end
            tick();
        end
    endtask

    function automatic int exp_seq(input int cbase, input int nbase, input int idx);
        return (idx < 4) ? cbase + idx : nbase + idx - 4;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vc = k[0]; vn = ~k[0]; ifft_ready = k[0];
            dci = DW'(50 + k); dni = DW'(60 + k); dcq = DW'(70 + k); dnq = DW'(80 + k);
            tick();
        end
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", ov); end
        tests++; if (oi !== '0 || oq !== '0) begin fails++; $display("FAIL reset_data got %0d/%0d want 0/0", oi, oq); end
        tests++; if (rc !== 1'b1 || rn !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b%0b want 11", rc, rn); end
        vc = 1'b0; vn = 1'b0; ifft_ready = 1'b0;
        reset = 1'b1;
        tick();
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_release_valid got %0b want 0", ov); end
    endtask

    task automatic test_basic();
        ifft_ready = 1'b1;
        fill_both(1, 11);
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL basic_valid_after_commit got %0b want 0", ov); end
        tick();
        tests++; if (ov !== 1'b1 || oi !== 16'sd1) begin fails++; $display("FAIL basic_first_out got v=%0b i=%0d want v=1 i=1", ov, oi); end
        tests++; if (rc !== 1'b0 || rn !== 1'b0) begin fails++; $display("FAIL basic_ready_during_send got %0b%0b want 00", rc, rn); end
        collect(16);
        tests++; if (got_n != 8) begin fails++; $display("FAIL basic_count got %0d want 8", got_n); end
        tests++; if (last_c - first_c + 1 != 8 || first_c != 0) begin fails++; $display("FAIL basic_valid_window got %0d..%0d want 0..7", first_c, last_c); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_i[i] != exp_seq(1, 11, i) || got_q[i] != -exp_seq(1, 11, i)) begin
                fails++; $display("FAIL basic_seq[%0d] got %0d/%0d want %0d/%0d", i, got_i[i], got_q[i], exp_seq(1, 11, i), -exp_seq(1, 11, i));
            end
        end
        tests++; if (rc !== 1'b1 || rn !== 1'b1) begin fails++; $display("FAIL basic_ready_reassert got %0b%0b want 11", rc, rn); end
    endtask

    task automatic test_unbalanced();
        int bad;
        fill_chet(1);
        tests++; if (rc !== 1'b0 || rn !== 1'b1) begin fails++; $display("FAIL unbal_ready_after_chet got %0b%0b want 01", rc, rn); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (ov !== 1'b0 || rc !== 1'b0) bad++;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            dni = DW'(11 + k); dnq = DW'(-(11 + k)); vn = 1'b1;
            if (ov !== 1'b0 || rc !== 1'b0 || rn !== 1'b1) bad++;
            tick();
        end
        vn = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL unbal_gap got %0d bad cycles want 0", bad); end
        collect(16);
        tests++; if (got_n != 8 || first_c != 1) begin fails++; $display("FAIL unbal_count got n=%0d first=%0d want n=8 first=1", got_n, first_c); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_i[i] != exp_seq(1, 11, i)) begin fails++; $display("FAIL unbal_seq[%0d] got %0d want %0d", i, got_i[i], exp_seq(1, 11, i)); end
        end
    endtask

    task automatic test_stall();
        int stalls, hold_bad, n;
        int seq [16];
        fill_both(1, 11);
        ifft_ready = 1'b1;
        stalls = 0; hold_bad = 0; n = 0;
        for (int c = 0; c < 30; c++) begin
            if (ov) begin
                if (oi == 16'sd12 && stalls < 3) begin
                    ifft_ready = 1'b0; stalls++;
                end else begin
                    ifft_ready = 1'b1;
                    if (n < 16) seq[n] = int'(oi);
                    n++;
                end
            end
            tick();
            if (!ifft_ready && (ov !== 1'b1 || oi !== 16'sd12)) hold_bad++;
        end
        ifft_ready = 1'b1;
        tests++; if (stalls != 3 || hold_bad != 0) begin fails++; $display("FAIL stall_hold got stalls=%0d bad=%0d want 3/0", stalls, hold_bad); end
        tests++; if (n != 8) begin fails++; $display("FAIL stall_count got %0d want 8", n); end
        for (int i = 0; i < 8 && i < n; i++) begin
            tests++;
            if (seq[i] != exp_seq(1, 11, i)) begin fails++; $display("FAIL stall_seq[%0d] got %0d want %0d", i, seq[i], exp_seq(1, 11, i)); end
        end
    endtask

    task automatic test_backpressure();
        int seen99;
        fill_chet(1);
        dci = 16'sd99; dcq = 16'sd99; vc = 1'b1;
        tests++; if (rc !== 1'b0) begin fails++; $display("FAIL bp_ready got %0b want 0", rc); end
        tick(); tick();
        vc = 1'b0;
        fill_nchet(11);
        collect(16);
        seen99 = 0;
        for (int i = 0; i < 8; i++) if (got_i[i] == 99) seen99++;
        tests++; if (seen99 != 0 || got_n != 8) begin fails++; $display("FAIL bp_no99 got seen=%0d n=%0d want 0/8", seen99, got_n); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_i[i] != exp_seq(1, 11, i)) begin fails++; $display("FAIL bp_seq[%0d] got %0d want %0d", i, got_i[i], exp_seq(1, 11, i)); end
        end
    endtask

    task automatic test_reset_mid_send();
        int found;
        fill_both(1, 11);
        ifft_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (ov && oi == 16'sd3) found = 1;
            else tick();
        end
        tests++; if (found == 0) begin fails++; $display("FAIL rst_mid_find got none want sample 3"); end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests++; if (ov !== 1'b0 || oi !== '0) begin fails++; $display("FAIL rst_mid_clear got v=%0b i=%0d want 0/0", ov, oi); end
        tests++; if (rc !== 1'b1 || rn !== 1'b1) begin fails++; $display("FAIL rst_mid_fill got %0b%0b want 11", rc, rn); end
        fill_both(21, 31);
        collect(16);
        tests++; if (got_n != 8) begin fails++; $display("FAIL rst_mid_count got %0d want 8", got_n); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_i[i] != exp_seq(21, 31, i)) begin fails++; $display("FAIL rst_mid_seq[%0d] got %0d want %0d", i, got_i[i], exp_seq(21, 31, i)); end
`ifdef IC_TWO_TO_SIFFT_LAST_EN
            tests++;
            if (got_l[i] != ((i == 7) ? 1 : 0)) begin fails++; $display("FAIL rst_mid_last[%0d] got %0d want %0d", i, got_l[i], (i == 7) ? 1 : 0); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int rise [3];
        int nr, n;
        int seq [16];
        logic prev;
        int exp_v;
        ifft_ready = 1'b1;
        nr = 0; n = 0; prev = 1'b0;
        for (int c = 0; c < 35; c++) begin
            dci = DW'(100 + c); dcq = DW'(-(100 + c)); vc = 1'b1;
            dni = DW'(200 + c); dnq = DW'(-(200 + c)); vn = 1'b1;
            tick();
            if (ov && !prev && nr < 3) begin rise[nr] = c; nr++; end
            if (ov && n < 16) begin seq[n] = int'(oi); n++; end
            prev = ov;
        end
        vc = 1'b0; vn = 1'b0;
        tests++; if (nr != 3 || rise[0] != 4 || rise[1] - rise[0] != 13 || rise[2] - rise[1] != 13) begin
            fails++; $display("FAIL b2b_period got nr=%0d r0=%0d r1=%0d r2=%0d want 3/4/17/30", nr, rise[0], rise[1], rise[2]);
        end
        for (int i = 0; i < 16; i++) begin
            exp_v = (i < 4) ? 100 + i : (i < 8) ? 196 + i : (i < 12) ? 105 + i : 201 + i;
            tests++;
            if (seq[i] != exp_v) begin fails++; $display("FAIL b2b_seq[%0d] got %0d want %0d", i, seq[i], exp_v); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0; vc = 1'b0; vn = 1'b0; ifft_ready = 1'b0;
        dci = '0; dcq = '0; dni = '0; dnq = '0;
        test_reset();
        test_basic();
        test_unbalanced();
        test_stall();
        test_backpressure();
        test_reset_mid_send();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
